// File: rtl/int_ctrl.sv
// int_ctrl: rising-edge interrupt latch with enable mask, fixed lowest-index
// priority and a single-outstanding ACK/EOI handshake toward the CPU.
// VEC_W must be wide enough to encode every source index (2**VEC_W >= N_SRC).
module int_ctrl #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 3
) (
  input  logic             CLK_WB,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] INT_SRC,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_DATA,
  input  logic [N_SRC-1:0] PEND_CLR,
  input  logic             IRQ_ACK,
  input  logic             IRQ_EOI,
  output logic             IRQ,
  output logic [VEC_W-1:0] IRQ_VEC,
  output logic             IN_SERVICE,
  output logic [N_SRC-1:0] PENDING
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   src_d_q, src_d_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               irq_q, irq_d;
  logic               in_svc_q, in_svc_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   ack_clr;
  logic [VEC_W-1:0]   winner;
  logic               winner_found;
  logic               vec_eligible;
  logic               ack_accept;

  // Edge detection, eligibility and priority selection of the lowest set index.
  always_comb begin
    rise         = INT_SRC & ~src_d_q;
    eligible     = pending_q & mask_q;
    winner       = '0;
    winner_found = 1'b0;
    vec_eligible = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !winner_found) begin
        winner       = VEC_W'(i);
        winner_found = 1'b1;
      end
      if (VEC_W'(i) == vec_q) begin
        vec_eligible = eligible[i];
      end
    end
  end

  // Next-state logic for the request FSM; registered IRQ/IN_SERVICE follow the next state.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    ack_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          vec_d   = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        if (IRQ_ACK) begin
          ack_accept = 1'b1;
          state_d    = SVC;
        end else if (!vec_eligible) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (IRQ_EOI) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    irq_d    = (state_d == REQ);
    in_svc_d = (state_d == SVC);
  end

  // Pending/mask/edge register updates; a new rise overrides any clear in the same cycle.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_accept && (VEC_W'(i) == vec_q)) begin
        ack_clr[i] = 1'b1;
      end
    end
    pending_d = (pending_q & ~(PEND_CLR | ack_clr)) | rise;
    mask_d    = MASK_WE ? MASK_DATA : mask_q;
    src_d_d   = INT_SRC;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK_WB or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      src_d_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      vec_q     <= '0;
      irq_q     <= 1'b0;
      in_svc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_d_q   <= src_d_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      vec_q     <= vec_d;
      irq_q     <= irq_d;
      in_svc_q  <= in_svc_d;
    end
  end

  assign IRQ        = irq_q;
  assign IRQ_VEC    = vec_q;
  assign IN_SERVICE = in_svc_q;
  assign PENDING    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus random traffic for int_ctrl, checked
// against a behavioural model of pending/mask/handshake rules.
module tb_int_ctrl;

  logic       CLK_WB;
  logic       RST_N;
  logic [7:0] INT_SRC;
  logic       MASK_WE;
  logic [7:0] MASK_DATA;
  logic [7:0] PEND_CLR;
  logic       IRQ_ACK;
  logic       IRQ_EOI;
  logic       IRQ;
  logic [2:0] IRQ_VEC;
  logic       IN_SERVICE;
  logic [7:0] PENDING;

  int vectors;
  int miscompares;

  // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = handler running.
  int         m_phase;
  int         m_vec;
  logic [7:0] m_pend;
  logic [7:0] m_mask;
  logic [7:0] m_prev;

  int_ctrl #(.N_SRC(8), .VEC_W(3)) dut (
    .CLK_WB     (CLK_WB),
    .RST_N      (RST_N),
    .INT_SRC    (INT_SRC),
    .MASK_WE    (MASK_WE),
    .MASK_DATA  (MASK_DATA),
    .PEND_CLR   (PEND_CLR),
    .IRQ_ACK    (IRQ_ACK),
    .IRQ_EOI    (IRQ_EOI),
    .IRQ        (IRQ),
    .IRQ_VEC    (IRQ_VEC),
    .IN_SERVICE (IN_SERVICE),
    .PENDING    (PENDING)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK_WB = 1'b0;
    forever #5 CLK_WB = ~CLK_WB;
  end

  task automatic modelReset();
    m_phase = 0;
    m_vec   = 0;
    m_pend  = 8'h00;
    m_mask  = 8'h00;
    m_prev  = 8'h00;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic modelEdge(input logic [7:0] src, input logic mwe, input logic [7:0] mdata,
                           input logic [7:0] clr, input logic ack, input logic eoi);
    logic [7:0] rise;
    logic [7:0] elig;
    logic [7:0] clear_set;
    int         next_phase;
    int         next_vec;
    rise       = src & ~m_prev;
    elig       = m_pend & m_mask;
    clear_set  = clr;
    next_phase = m_phase;
    next_vec   = m_vec;
    if (m_phase == 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (elig[i]) begin
          next_vec   = i;
          next_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (ack) begin
        clear_set  = clear_set | (8'h01 << m_vec);
        next_phase = 2;
      end else if (elig[m_vec] == 1'b0) begin
        next_phase = 0;
      end
    end else begin
      if (eoi) next_phase = 0;
    end
    m_pend  = (m_pend & ~clear_set) | rise;
    if (mwe) m_mask = mdata;
    m_prev  = src;
    m_phase = next_phase;
    m_vec   = next_vec;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".IRQ"},        32'(IRQ),        32'(m_phase == 1));
    checkValue({tag, ".IRQ_VEC"},    32'(IRQ_VEC),    32'(m_vec));
    checkValue({tag, ".IN_SERVICE"}, 32'(IN_SERVICE), 32'(m_phase == 2));
    checkValue({tag, ".PENDING"},    32'(PENDING),    32'(m_pend));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic applyStimulus(input string tag, input logic [7:0] src, input logic mwe,
                               input logic [7:0] mdata, input logic [7:0] clr,
                               input logic ack, input logic eoi);
    @(negedge CLK_WB);
    INT_SRC   = src;
    MASK_WE   = mwe;
    MASK_DATA = mdata;
    PEND_CLR  = clr;
    IRQ_ACK   = ack;
    IRQ_EOI   = eoi;
    @(posedge CLK_WB);
    modelEdge(src, mwe, mdata, clr, ack, eoi);
    #1;
    checkOutput(tag);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    logic [7:0] drv_src;
    logic [7:0] r_clr;
    int         irq_rises;
    logic       last_irq;

    vectors     = 0;
    miscompares = 0;
    RST_N       = 1'b0;
    INT_SRC     = 8'h00;
    MASK_WE     = 1'b0;
    MASK_DATA   = 8'h00;
    PEND_CLR    = 8'h00;
    IRQ_ACK     = 1'b0;
    IRQ_EOI     = 1'b0;
    modelReset();
    repeat (3) @(posedge CLK_WB);
    #1;
    checkOutput("reset");
    @(negedge CLK_WB);
    RST_N = 1'b1;

    // Single pulse on the timer line with only bit 0 enabled.
    applyStimulus("t1.mask", 8'h00, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    applyStimulus("t1.idle", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus("t1.pulse", 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t1.pend_set", 32'(PENDING), 32'h01);
    checkValue("t1.irq_not_yet", 32'(IRQ), 32'h0);
    applyStimulus("t1.req", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t1.irq", 32'(IRQ), 32'h1);
    checkValue("t1.vec", 32'(IRQ_VEC), 32'h0);
    applyStimulus("t1.ack", 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkValue("t1.insvc", 32'(IN_SERVICE), 32'h1);
    applyStimulus("t1.eoi", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Level held for 50 cycles must raise exactly one request.
    irq_rises = 0;
    last_irq  = IRQ;
    for (int i = 0; i < 50; i++) begin
      applyStimulus("t2.hold", 8'h01, 1'b0, 8'h00, 8'h00, (i == 4), (i == 8));
      if (IRQ && !last_irq) irq_rises++;
      last_irq = IRQ;
    end
    checkValue("t2.irq_count", 32'(irq_rises), 32'd1);
    checkValue("t2.pend_clear", 32'(PENDING), 32'h00);
    applyStimulus("t2.release", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Simultaneous rises on bits 5 and 2: lowest index served first.
    applyStimulus("t3.mask", 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
    applyStimulus("t3.rise", 8'h24, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus("t3.req2", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t3.vec2", 32'(IRQ_VEC), 32'd2);
    applyStimulus("t3.ack2", 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkValue("t3.pend_after_ack", 32'(PENDING), 32'h20);
    applyStimulus("t3.eoi2", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus("t3.req5", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t3.vec5", 32'(IRQ_VEC), 32'd5);
    checkValue("t3.irq5", 32'(IRQ), 32'h1);
    applyStimulus("t3.ack5", 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus("t3.eoi5", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Masking the requested source withdraws the request but keeps it pending.
    applyStimulus("t4.rise", 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus("t4.req", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t4.vec3", 32'(IRQ_VEC), 32'd3);
    applyStimulus("t4.mask", 8'h00, 1'b1, 8'hF7, 8'h00, 1'b0, 1'b0);
    applyStimulus("t4.withdraw", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkValue("t4.irq_drop", 32'(IRQ), 32'h0);
    checkValue("t4.pend3", 32'(PENDING), 32'h08);
    applyStimulus("t4.clr", 8'h00, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0);

    // Set beats clear; stray EOI/ACK strobes are ignored.
    applyStimulus("t5.setclr", 8'h02, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0);
    checkValue("t5.pend1", 32'(PENDING), 32'h02);
    applyStimulus("t5.eoi_idle", 8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkValue("t5.vec1", 32'(IRQ_VEC), 32'd1);
    applyStimulus("t5.ack", 8'h02, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus("t5.ack_svc", 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkValue("t5.still_svc", 32'(IN_SERVICE), 32'h1);
    applyStimulus("t5.eoi", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus("t5.eoi_again", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset while a handler is active.
    applyStimulus("t6.rise", 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus("t6.req", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus("t6.ack", 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkValue("t6.insvc_before", 32'(IN_SERVICE), 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    checkValue("t6.async_insvc", 32'(IN_SERVICE), 32'h0);
    checkValue("t6.async_pend", 32'(PENDING), 32'h00);
    checkValue("t6.async_vec", 32'(IRQ_VEC), 32'h0);
    modelReset();
    IRQ_ACK = 1'b0;
    repeat (2) @(posedge CLK_WB);
    @(negedge CLK_WB);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t6.quiet", 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    checkValue("t6.no_irq", 32'(IRQ), 32'h0);

    // Random traffic against the model.
    drv_src = 8'h00;
    for (int i = 0; i < 400; i++) begin
      drv_src = drv_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      r_clr   = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      applyStimulus("rand", drv_src, ($urandom_range(0, 15) == 0), 8'($urandom), r_clr,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
